// File: rtl/rom_burst_reader_pkg.sv
// Shared constants, types and helpers for the ROM burst reader.
// The optional checksum output is enabled with the ROM_BURST_CHECKSUM_EN macro.
package rom_pkg;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int ROM_DEPTH  = 64;
  localparam int FIFO_DEPTH = 2;

  // Longest burst. Longer requests are clamped to this so that no address is read twice.
  localparam logic [ADDR_W:0] LEN_MAX = ROM_DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

endpackage

// File: rtl/rom_burst_reader_if.sv
// Bundles the request, ROM and stream signals of the burst reader.
// The checksum signal is present only when ROM_BURST_CHECKSUM_EN is defined.
interface rom_burst_reader_if;
  import rom_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   burst_len;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_add;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef ROM_BURST_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // The burst reader itself.
  modport master (
`ifdef ROM_BURST_CHECKSUM_EN
    output checksum,
`endif
    input  start, base_addr, burst_len, rom_data, out_ready,
    output busy, done, rom_en, rom_add, out_valid, out_data, out_last
  );

  // The requester, the ROM and the stream consumer.
  modport slave (
`ifdef ROM_BURST_CHECKSUM_EN
    input  checksum,
`endif
    output start, base_addr, burst_len, rom_data, out_ready,
    input  busy, done, rom_en, rom_add, out_valid, out_data, out_last
  );

endinterface

// File: rtl/rom_skid_fifo.sv
// Two-entry capture buffer holding {last, data} words read back from the ROM.
// A push and a pop in the same cycle both take effect, so the count is unchanged.
module rom_skid_fifo
  import rom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  fifo_word_t push_word_i,
  input  logic       pop_i,
  output fifo_word_t head_o,
  output logic [1:0] count_o
);

  fifo_word_t mem_q [FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  // Storage, pointers and occupancy. Storage is cleared so out_data resets to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_word_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rom_burst_reader.sv
// Sequences burst reads from the 64x8 synchronous ROM and presents the words as a
// valid/ready byte stream with a last marker. Reads are issued only while the
// capture buffer plus the word in flight leaves room, so backpressure never drops data.
// Defining ROM_BURST_CHECKSUM_EN adds an XOR checksum of the words transferred.
//
// state | meaning
// IDLE  | waiting for start with a non-zero length
// READ  | issuing ROM reads until the last address has been issued
// DRAIN | waiting for the last word to leave the stream
// DONE  | done pulse, then back to IDLE
module rom_burst_reader
  import rom_pkg::*;
(
  input logic              clk,
  input logic              rst,
  rom_burst_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic              inflight_q;
  logic              last_inflight_q;
  logic              busy_q;
  logic              done_q;

  fifo_word_t        head;
  fifo_word_t        push_word;
  logic [1:0]        fifo_count;
  logic              out_valid;
  logic              pop;
  logic [2:0]        occupancy;
  logic              issue;
  logic              accept;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & bus.out_ready;
  // Words held or in flight after this cycle's pop; never negative since pop implies a held word.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == READ) && (occupancy < 3'd2);
  assign accept    = (state_q == IDLE) && bus.start && (bus.burst_len != '0);
  assign push_word = {last_inflight_q, bus.rom_data};

  rom_skid_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_word_i (push_word),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // Burst FSM with address/length counters and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      last_inflight_q <= issue && (remain_q == LEN_ONE);
      done_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= bus.base_addr;
            remain_q <= clamp_len(bus.burst_len);
            busy_q   <= 1'b1;
            state_q  <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_q   <= addr_q + ADDR_ONE;
            remain_q <= remain_q - LEN_ONE;
            if (remain_q == LEN_ONE) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ROM_BURST_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  // Running XOR of transferred words, cleared when a burst is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= '0;
    end else if (pop) begin
      chk_q <= chk_q ^ head.data;
    end
  end

  assign bus.checksum = chk_q;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rom_en    = issue;
  assign bus.rom_add   = addr_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader paired with a 1-cycle-latency ROM model
// whose contents are addr ^ 8'hA5.
module tb_rom_burst_reader;
  import rom_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_burst_reader_if bus();

  rom_burst_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: registered read data, one cycle after rom_en.
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= {2'b00, bus.rom_add} ^ 8'hA5;
  end

  int tests = 0;
  int fails = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  logic [5:0] got_addr[$];
  int         issue_cyc[$];
  int         pop_cyc[$];
  int         done_cnt;
  int         done_cyc;
  int         viol;
  logic       busy_c1;

  function automatic logic [7:0] rom_val(input logic [5:0] a);
    return {2'b00, a} ^ 8'hA5;
  endfunction

  // Starts a burst (caller sits just after a rising edge) and records everything
  // seen on the ROM and stream sides until done or the cycle budget expires.
  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic run_burst(input logic [5:0] b, input logic [6:0] l, input int mode,
                           input bit hold_start, input int budget);
    int   issued;
    int   popped;
    logic pop;
    issued = 0;
    popped = 0;
    got_data.delete(); got_last.delete(); got_addr.delete();
    issue_cyc.delete(); pop_cyc.delete();
    done_cnt = 0; done_cyc = 0; viol = 0; busy_c1 = 1'b0;
    bus.start = 1'b1; bus.base_addr = b; bus.burst_len = l; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    if (hold_start) begin
      bus.base_addr = 6'd40;
      bus.burst_len = 7'd5;
    end else begin
      bus.start = 1'b0;
    end
    for (int c = 1; c <= budget; c++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      @(negedge clk);
      if (c == 1) busy_c1 = bus.busy;
      pop = bus.out_valid && bus.out_ready;
      if (bus.rom_en) begin
        if (issued - popped - int'(pop) >= 2) viol++;
        issued++;
        got_addr.push_back(bus.rom_add);
        issue_cyc.push_back(c);
      end
      if (pop) begin
        popped++;
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        pop_cyc.push_back(c);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
        bus.start = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst = 1'b1; bus.start = 1'b0; bus.base_addr = '0; bus.burst_len = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.rom_en, bus.rom_add, bus.out_valid, bus.out_data, bus.out_last} !== '0) begin
      fails++;
      $display("FAIL reset_values: busy=%b done=%b rom_en=%b rom_add=%0d out_valid=%b out_data=%h out_last=%b, required all 0",
               bus.busy, bus.done, bus.rom_en, bus.rom_add, bus.out_valid, bus.out_data, bus.out_last);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.rom_en || bus.busy) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  // Generic burst scenario: words, order, last tag and addresses against the ROM model.
  task automatic test_burst(input string name, input logic [5:0] b, input logic [6:0] l,
                            input int mode, input int budget);
    int         n;
    int         bad;
    logic [5:0] a;
    n = (l > 7'd64) ? 64 : int'(l);
    run_burst(b, l, mode, 1'b0, budget);
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL %s_done: done pulses %0d, required 1 within %0d cycles", name, done_cnt, budget);
    end
    tests++;
    if (got_data.size() != n || got_addr.size() != n) begin
      fails++;
      $display("FAIL %s_count: words %0d issues %0d, required %0d", name, got_data.size(), got_addr.size(), n);
    end else begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        a = b + 6'(i);
        if (got_addr[i] !== a || got_data[i] !== rom_val(a) || got_last[i] !== (i == n - 1)) begin
          bad++;
          if (bad <= 4)
            $display("FAIL %s_word%0d: addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                     name, i, got_addr[i], got_data[i], got_last[i], a, rom_val(a), (i == n - 1));
        end
      end
      tests++;
      if (bad != 0) fails++;
    end
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL %s_overissue: %0d issues with buffer full, required 0", name, viol);
    end
  endtask

  task automatic test_basic_timing();
    test_burst("basic", 6'd4, 7'd3, 0, 20);
    tests++;
    if (!busy_c1) begin
      fails++;
      $display("FAIL basic_busy: busy=%b in cycle 1, required 1", busy_c1);
    end
    tests++;
    if (issue_cyc.size() != 3 || issue_cyc[0] != 1 || issue_cyc[1] != 2 || issue_cyc[2] != 3) begin
      fails++;
      $display("FAIL basic_issue_cycles: %0d issues first at %0d, required cycles 1,2,3",
               issue_cyc.size(), (issue_cyc.size() > 0) ? issue_cyc[0] : -1);
    end
    tests++;
    if (pop_cyc.size() != 3 || pop_cyc[0] != 3 || pop_cyc[1] != 4 || pop_cyc[2] != 5) begin
      fails++;
      $display("FAIL basic_out_cycles: %0d words first at %0d, required cycles 3,4,5",
               pop_cyc.size(), (pop_cyc.size() > 0) ? pop_cyc[0] : -1);
    end
    tests++;
    if (done_cyc != 6) begin
      fails++;
      $display("FAIL basic_done_cycle: done in cycle %0d, required 6", done_cyc);
    end
`ifdef ROM_BURST_CHECKSUM_EN
    tests++;
    if (bus.checksum !== 8'hA2) begin
      fails++;
      $display("FAIL basic_checksum: %h, required a2", bus.checksum);
    end
`endif
  endtask

  task automatic test_zero_len();
    int bad;
    bad = 0;
    bus.start = 1'b1; bus.base_addr = 6'd5; bus.burst_len = 7'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rom_en || bus.busy || bus.done || bus.out_valid) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL zero_len: %0d active cycles, required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int bad;
    bad = 0;
    run_burst(6'd4, 7'd3, 0, 1'b1, 20);
    tests++;
    if (done_cnt != 1 || got_data.size() != 3) begin
      fails++;
      $display("FAIL busy_start_count: done %0d words %0d, required 1 and 3", done_cnt, got_data.size());
    end else begin
      tests++;
      if (got_data[0] !== 8'hA1 || got_data[1] !== 8'hA0 || got_data[2] !== 8'hA3) begin
        fails++;
        $display("FAIL busy_start_data: %h %h %h, required a1 a0 a3", got_data[0], got_data[1], got_data[2]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.busy || bus.rom_en) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL busy_start_restart: %0d active cycles after done, required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    int bad;
    bad = 0;
    bus.start = 1'b1; bus.base_addr = 6'd0; bus.burst_len = 7'd10; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.rom_en, bus.rom_add, bus.out_valid, bus.out_data, bus.out_last} !== '0) begin
      fails++;
      $display("FAIL rst_mid_values: busy=%b done=%b rom_en=%b rom_add=%0d out_valid=%b out_data=%h out_last=%b, required all 0",
               bus.busy, bus.done, bus.rom_en, bus.rom_add, bus.out_valid, bus.out_data, bus.out_last);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done || bus.out_valid || bus.busy) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_mid_quiet: %0d active cycles after reset, required 0", bad);
    end
    @(posedge clk); #1;
    test_burst("post_rst", 6'd23, 7'd1, 0, 20);
    tests++;
    if (got_data.size() != 1 || got_data[0] !== 8'hB2 || got_last[0] !== 1'b1) begin
      fails++;
      $display("FAIL post_rst_word: %0d words first=%h, required one word b2 with last",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'h00);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.burst_len = '0; bus.out_ready = 1'b1;
    test_reset();
    test_basic_timing();
    test_burst("wrap", 6'd62, 7'd4, 0, 20);
    test_burst("backpressure", 6'd14, 7'd5, 1, 60);
    test_zero_len();
    test_start_ignored();
    test_rst_mid();
    test_burst("len64_clamp", 6'h20, 7'd100, 0, 120);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
